conv_pool_scan_ctrl: RTL and testbench

CONV_POOL_SCAN_CTRL -- requirements
Module: conv_pool_scan_ctrl

---
 rtl/conv_pool_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_conv_pool_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_scan_ctrl.sv
// -----------------------------------------------------------------------------
// conv_pool_scan_ctrl
// Raster-scan controller for a KxK / stride-2 window pooling engine. It reads
// the input image once in row-major order, drives the window_buffer shift
// enable one cycle behind each read, and raises a pooled-result write two
// cycles after the read of every pixel that completes a window.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset
//   start_i    : begin a full-image scan (honoured in IDLE only)
//   abort_i    : cancel a scan in RUN/DRAIN; block is IDLE on the next cycle
//   rd_addr_o  : input RAM read address (row-major pixel index)
//   rd_en_o    : read issued this cycle
//   sh_en_o    : window_buffer shift enable (rd_en_o delayed one cycle)
//   wr_addr_o  : output RAM write address (pooled-result index)
//   wr_en_o    : pooled result valid this cycle
//   busy_o     : scan in progress (RUN or DRAIN)
//   done_o     : one-cycle completion pulse
// -----------------------------------------------------------------------------
module conv_pool_scan_ctrl #(
  parameter int ADDR_WIDTH  = 16,
  parameter int N_ROWS      = 108,
  parameter int N_COLS      = 160,
  parameter int KERNEL_SIZE = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  rd_en_o,
  output logic                  sh_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic                  wr_en_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int   ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int   COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int   K_M1  = KERNEL_SIZE - 1;
  // Window origins sit on even offsets from K-1, so only the LSB parity of
  // row/col relative to K-1 matters.
  localparam logic K_PAR = 1'(K_M1 % 2);

  if (64'(N_ROWS) * 64'(N_COLS) > (64'd1 << ADDR_WIDTH)) begin : g_bad_addr
    $error("conv_pool_scan_ctrl: image does not fit in ADDR_WIDTH");
  end
  if (KERNEL_SIZE > N_ROWS || KERNEL_SIZE > N_COLS) begin : g_bad_kernel
    $error("conv_pool_scan_ctrl: KERNEL_SIZE larger than image");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [ROW_W-1:0]      r_row;
  logic [COL_W-1:0]      r_col;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic                  r_drain_cnt;
  logic                  r_sh;
  // [0]: window-complete read one cycle ago, [1]: two cycles ago (= write)
  logic [1:0]            r_win_pipe;

  logic w_last, w_win, w_start, w_flush, w_run;

  assign w_run   = (r_state == S_RUN);
  assign w_last  = (r_row == ROW_W'(N_ROWS - 1)) && (r_col == COL_W'(N_COLS - 1));
  assign w_win   = (r_row >= ROW_W'(K_M1)) && (r_col >= COL_W'(K_M1)) &&
                   (r_row[0] == K_PAR) && (r_col[0] == K_PAR);
  assign w_start = (r_state == S_IDLE) && start_i && !abort_i;
  assign w_flush = abort_i && (w_run || (r_state == S_DRAIN));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_RUN;
      S_RUN:   if (abort_i) w_next = S_IDLE;
               else if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (abort_i) w_next = S_IDLE;
               else if (r_drain_cnt) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_row       <= '0;
      r_col       <= '0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_drain_cnt <= 1'b0;
      r_sh        <= 1'b0;
      r_win_pipe  <= '0;
    end else begin
      if (w_start) begin
        r_row     <= '0;
        r_col     <= '0;
        r_rd_addr <= '0;
      end else if (w_run && !w_last) begin
        r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
        if (r_col == COL_W'(N_COLS - 1)) begin
          r_col <= '0;
          r_row <= r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      if (w_start)            r_wr_addr <= '0;
      else if (r_win_pipe[1]) r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);

      // Two DRAIN cycles: flag low in the first, high in the second.
      r_drain_cnt <= (r_state == S_DRAIN) && !r_drain_cnt;

      // Abort kills in-flight shift/write flags so nothing leaks after IDLE.
      if (w_flush) begin
        r_sh       <= 1'b0;
        r_win_pipe <= '0;
      end else begin
        r_sh       <= w_run;
        r_win_pipe <= {r_win_pipe[0], w_run && w_win};
      end
    end
  end

  assign rd_addr_o = r_rd_addr;
  assign rd_en_o   = w_run;
  assign sh_en_o   = r_sh;
  assign wr_addr_o = r_wr_addr;
  assign wr_en_o   = r_win_pipe[1];
  assign busy_o    = w_run || (r_state == S_DRAIN);
  assign done_o    = (r_state == S_DONE);

endmodule

// File: tb/tb_conv_pool_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv_pool_scan_ctrl
// Directed bench: a 6x8 instance for cycle-exact checks and a default-size
// instance for the full-image counts. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_conv_pool_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // small 6x8 instance
  logic        s_start, s_abort, s_rd_en, s_sh, s_wr_en, s_busy, s_done;
  logic [15:0] s_rd_addr, s_wr_addr;
  // default-size instance
  logic        d_start, d_abort, d_rd_en, d_sh, d_wr_en, d_busy, d_done;
  logic [15:0] d_rd_addr, d_wr_addr;

  conv_pool_scan_ctrl #(.ADDR_WIDTH(16), .N_ROWS(6), .N_COLS(8), .KERNEL_SIZE(4)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .abort_i(s_abort),
    .rd_addr_o(s_rd_addr), .rd_en_o(s_rd_en), .sh_en_o(s_sh),
    .wr_addr_o(s_wr_addr), .wr_en_o(s_wr_en), .busy_o(s_busy), .done_o(s_done));

  conv_pool_scan_ctrl u_dflt (
    .clk_i(clk), .rst_i(rst), .start_i(d_start), .abort_i(d_abort),
    .rd_addr_o(d_rd_addr), .rd_en_o(d_rd_en), .sh_en_o(d_sh),
    .wr_addr_o(d_wr_addr), .wr_en_o(d_wr_en), .busy_o(d_busy), .done_o(d_done));

  task automatic test_reset();
    rst = 1'b1;
    s_start = 1'b0; s_abort = 1'b0; d_start = 1'b0; d_abort = 1'b0;
    #2;
    n_cmp++;
    if ({s_rd_en, s_sh, s_wr_en, s_busy, s_done} !== 5'b0) begin
      n_err++; $display("FAIL reset_small_flags: got %b want 00000", {s_rd_en, s_sh, s_wr_en, s_busy, s_done});
    end
    n_cmp++;
    if ({s_rd_addr, s_wr_addr} !== 32'h0) begin
      n_err++; $display("FAIL reset_small_addr: got rd=%0h wr=%0h want 0", s_rd_addr, s_wr_addr);
    end
    n_cmp++;
    if ({d_rd_en, d_sh, d_wr_en, d_busy, d_done} !== 5'b0) begin
      n_err++; $display("FAIL reset_dflt_flags: got %b want 00000", {d_rd_en, d_sh, d_wr_en, d_busy, d_done});
    end
    n_cmp++;
    if ({d_rd_addr, d_wr_addr} !== 32'h0) begin
      n_err++; $display("FAIL reset_dflt_addr: got rd=%0h wr=%0h want 0", d_rd_addr, d_wr_addr);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Full 6x8 scan from IDLE with cycle-exact expectations relative to t0.
  task automatic test_small_scan();
    int          exp_k[6] = '{29, 31, 33, 45, 47, 49};
    int          wr_k[$];
    logic [15:0] wr_a[$];
    int          done_k[$];
    int          rd_first = -1, rd_last = -1, rd_cnt = 0;
    int          bz_first = -1, bz_last = -1;
    int          addr_bad = 0, sh_bad = 0;
    logic        prev_rd = 1'b0;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (s_sh !== prev_rd) sh_bad++;
      prev_rd = s_rd_en;
      if (s_rd_en === 1'b1) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = k;
        rd_last = k;
        if (s_rd_addr !== 16'(k)) addr_bad++;
      end
      if (s_busy === 1'b1) begin
        if (bz_first < 0) bz_first = k;
        bz_last = k;
      end
      if (s_wr_en === 1'b1) begin wr_k.push_back(k); wr_a.push_back(s_wr_addr); end
      if (s_done === 1'b1) done_k.push_back(k);
    end
    n_cmp++;
    if (wr_k.size() != 6) begin
      n_err++; $display("FAIL small_wr_count: got %0d want 6", wr_k.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (wr_k[i] != exp_k[i] || wr_a[i] !== 16'(i)) begin
          n_err++; $display("FAIL small_wr_%0d: got t0+%0d addr %0d want t0+%0d addr %0d", i, wr_k[i], wr_a[i], exp_k[i], i);
        end
      end
    end
    n_cmp++;
    if (rd_first != 0 || rd_last != 47 || rd_cnt != 48) begin
      n_err++; $display("FAIL small_rd_window: got first=%0d last=%0d cnt=%0d want 0/47/48", rd_first, rd_last, rd_cnt);
    end
    n_cmp++;
    if (addr_bad != 0) begin
      n_err++; $display("FAIL small_rd_addr: got %0d bad addresses want 0", addr_bad);
    end
    n_cmp++;
    if (bz_first != 0 || bz_last != 49) begin
      n_err++; $display("FAIL small_busy: got %0d..%0d want 0..49", bz_first, bz_last);
    end
    n_cmp++;
    if (done_k.size() != 1 || done_k[0] != 50) begin
      n_err++; $display("FAIL small_done: got %0d pulses first t0+%0d want 1 at t0+50", done_k.size(), (done_k.size() > 0) ? done_k[0] : -1);
    end
    n_cmp++;
    if (sh_bad != 0) begin
      n_err++; $display("FAIL small_sh_en: got %0d cycles off want 0", sh_bad);
    end
  endtask

  task automatic test_default_scan();
    int   wr_cnt = 0, rd_cnt = 0, done_cnt = 0, seq_bad = 0, sh_bad = 0;
    int   last_wr = -1, last_rd = -1;
    logic prev_rd = 1'b0;
    @(posedge clk); #1 d_start = 1'b1;
    @(posedge clk); #1 d_start = 1'b0;
    for (int k = 0; k < 17400; k++) begin
      @(negedge clk);
      if (d_sh !== prev_rd) sh_bad++;
      prev_rd = d_rd_en;
      if (d_rd_en === 1'b1) begin rd_cnt++; last_rd = int'(d_rd_addr); end
      if (d_wr_en === 1'b1) begin
        if (d_wr_addr !== 16'(wr_cnt)) seq_bad++;
        last_wr = int'(d_wr_addr);
        wr_cnt++;
      end
      if (d_done === 1'b1) done_cnt++;
    end
    n_cmp++;
    if (wr_cnt != 4187) begin
      n_err++; $display("FAIL dflt_wr_count: got %0d want 4187", wr_cnt);
    end
    n_cmp++;
    if (last_wr != 4186 || seq_bad != 0) begin
      n_err++; $display("FAIL dflt_wr_addr: got last=%0d seq_bad=%0d want 4186/0", last_wr, seq_bad);
    end
    n_cmp++;
    if (last_rd != 17279 || rd_cnt != 17280) begin
      n_err++; $display("FAIL dflt_rd: got last=%0d cnt=%0d want 17279/17280", last_rd, rd_cnt);
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++; $display("FAIL dflt_done: got %0d want 1", done_cnt);
    end
    n_cmp++;
    if (sh_bad != 0) begin
      n_err++; $display("FAIL dflt_sh_en: got %0d cycles off want 0", sh_bad);
    end
  endtask

  // Abort in cycle t0+30 (one write already out, next one in flight).
  task automatic test_abort();
    int   wr_pre = 0, post_bad = 0, sh_bad = 0;
    logic prev_rd = 1'b0, prev_ab = 1'b0;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      s_abort = (k == 30);
      @(negedge clk);
      if (s_sh !== (prev_rd && !prev_ab)) sh_bad++;
      prev_rd = s_rd_en;
      prev_ab = s_abort;
      if (k <= 30 && s_wr_en === 1'b1) wr_pre++;
      if (k >= 31 && {s_rd_en, s_sh, s_wr_en, s_busy, s_done} !== 5'b0) post_bad++;
    end
    s_abort = 1'b0;
    n_cmp++;
    if (wr_pre != 1) begin
      n_err++; $display("FAIL abort_pre_writes: got %0d want 1", wr_pre);
    end
    n_cmp++;
    if (post_bad != 0) begin
      n_err++; $display("FAIL abort_quiet: got %0d active cycles after abort want 0", post_bad);
    end
    n_cmp++;
    if (sh_bad != 0) begin
      n_err++; $display("FAIL abort_sh_en: got %0d cycles off want 0", sh_bad);
    end
    test_small_scan();
  endtask

  task automatic test_start_held();
    int   rd_cnt = 0, rd_last = -1, wr_cnt = 0, done_cnt = 0, sh_bad = 0;
    logic prev_rd = 1'b0;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 52; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (s_sh !== prev_rd) sh_bad++;
      prev_rd = s_rd_en;
      if (s_rd_en === 1'b1) begin rd_cnt++; rd_last = k; end
      if (s_wr_en === 1'b1) wr_cnt++;
      if (s_done === 1'b1) done_cnt++;
    end
    n_cmp++;
    if (rd_cnt != 48 || rd_last != 47) begin
      n_err++; $display("FAIL held_no_restart: got rd cnt=%0d last=%0d want 48/47", rd_cnt, rd_last);
    end
    n_cmp++;
    if (wr_cnt != 6 || done_cnt != 1) begin
      n_err++; $display("FAIL held_results: got wr=%0d done=%0d want 6/1", wr_cnt, done_cnt);
    end
    n_cmp++;
    if (sh_bad != 0) begin
      n_err++; $display("FAIL held_sh_en: got %0d cycles off want 0", sh_bad);
    end
    // start still high re-arms a scan from IDLE; abort it to get back to IDLE
    @(posedge clk); #1 s_start = 1'b0; s_abort = 1'b1;
    @(posedge clk); #1 s_abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({s_busy, s_rd_en, s_sh, s_wr_en} !== 4'b0) begin
      n_err++; $display("FAIL held_cleanup: got %b want 0000", {s_busy, s_rd_en, s_sh, s_wr_en});
    end
  endtask

  task automatic test_start_abort();
    int bad = 0;
    @(posedge clk); #1 s_start = 1'b1; s_abort = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if ({s_busy, s_rd_en, s_sh, s_done} !== 4'b0) bad++;
    end
    s_start = 1'b0; s_abort = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL start_abort_idle: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      else @(negedge clk);
    end
    n_cmp++;
    if (s_rd_en !== 1'b1 || s_rd_addr !== 16'd20) begin
      n_err++; $display("FAIL areset_pre: got rd_en=%b addr=%0d want 1/20", s_rd_en, s_rd_addr);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({s_rd_en, s_sh, s_wr_en, s_busy, s_done} !== 5'b0 || {s_rd_addr, s_wr_addr} !== 32'h0) begin
      n_err++; $display("FAIL areset_async: got flags=%b rd=%0d wr=%0d want 0", {s_rd_en, s_sh, s_wr_en, s_busy, s_done}, s_rd_addr, s_wr_addr);
    end
    @(posedge clk); @(negedge clk); @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if ({s_busy, s_rd_en, s_sh} !== 3'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL areset_wait_idle: got %0d active cycles want 0", bad);
    end
    test_small_scan();
  endtask

  initial begin
    test_reset();
    test_small_scan();
    test_default_scan();
    test_abort();
    test_start_held();
    test_start_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
